// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores onto a synchronous-read, word-organised data memory.
// Latency: load 3, sub-word store 3 (read-modify-write), word store 1; busy stalls the pipeline.
// Optional MEM_ACCESS_ALIGN_CHECK_EN: misaligned/illegal/out-of-range requests get a 1-cycle error response.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_rr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_w_mask,
    output logic [3:0]  mem_r_mask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, FETCH, CAPT, LRESP, WRITE, ERR} state_t;

    state_t      state;
    logic        lt_we;
    logic [1:0]  lt_size;
    logic        lt_unsigned;
    logic [31:0] lt_addr;
    logic [31:0] lt_wdata;
    logic [31:0] rdata_q;
    logic        accept;
    logic        req_bad;
    logic [31:0] lane_shift;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [31:0] addr_wrap;

    assign accept = req_valid && req_ready;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
        if (req_addr >= 32'(MEM_BYTES))
            req_bad = 1'b1;
    end
`else
    assign req_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lt_we       <= 1'b0;
            lt_size     <= 2'b00;
            lt_unsigned <= 1'b0;
            lt_addr     <= 32'd0;
            lt_wdata    <= 32'd0;
            rdata_q     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lt_we       <= req_we;
                        lt_size     <= req_size;
                        lt_unsigned <= req_unsigned;
                        lt_addr     <= req_addr;
                        lt_wdata    <= req_wdata;
                        // size 11 shares the word path when unchecked
                        if (req_bad)
                            state <= ERR;
                        else if (req_we && req_size[1])
                            state <= WRITE;
                        else
                            state <= FETCH;
                    end
                end
                FETCH: state <= CAPT;
                CAPT:  state <= lt_we ? WRITE : LRESP;
                LRESP: begin
                    rdata_q <= load_val;
                    state   <= IDLE;
                end
                WRITE:   state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        lane_shift = mem_rdata >> {lt_addr[1:0], 3'b000};
        byte_lane  = lane_shift[7:0];
        half_lane  = lt_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lt_size)
            2'b00:   load_val = {{24{~lt_unsigned & byte_lane[7]}}, byte_lane};
            2'b01:   load_val = {{16{~lt_unsigned & half_lane[15]}}, half_lane};
            default: load_val = mem_rdata;
        endcase
    end

    always_comb begin
        merged = mem_rdata;
        if (lt_size == 2'b00) begin
            case (lt_addr[1:0])
                2'd0:    merged[7:0]   = lt_wdata[7:0];
                2'd1:    merged[15:8]  = lt_wdata[7:0];
                2'd2:    merged[23:16] = lt_wdata[7:0];
                default: merged[31:24] = lt_wdata[7:0];
            endcase
        end else if (lt_addr[1]) begin
            merged[31:16] = lt_wdata[15:0];
        end else begin
            merged[15:0] = lt_wdata[15:0];
        end
    end

    // MEM_BYTES is a power of two, so the wrap is a mask
    assign addr_wrap = lt_addr & (32'(MEM_BYTES) - 32'd1);

    assign req_ready  = (state == IDLE);
    assign busy       = !req_ready;
    assign mem_ce     = (state == FETCH) || (state == CAPT) || (state == WRITE);
    assign mem_rr     = (state == CAPT);
    assign mem_we     = (state == WRITE);
    assign mem_addr   = (state == IDLE) ? 32'd0 : {addr_wrap[31:2], 2'b00};
    assign mem_wdata  = (state != WRITE) ? 32'd0 : (lt_size[1] ? lt_wdata : merged);
    assign mem_w_mask = 4'b1111;
    assign mem_r_mask = 4'b1111;
    assign resp_valid = (state == LRESP) || (state == WRITE) || (state == ERR);
    assign resp_rdata = (state == LRESP) ? load_val : rdata_q;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    assign resp_err   = (state == ERR);
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: synchronous-read memory model, directed vector table and random
// requests checked against a byte-array reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic        mem_ce, mem_we, mem_rr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_w_mask, mem_r_mask;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .mem_ce(mem_ce), .mem_we(mem_we),
        .mem_rr(mem_rr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask), .mem_rdata(mem_rdata)
    );

    // Data memory: fetch latches the word, read-register publishes it next cycle.
    logic [31:0] mem_arr [1024];
    logic [31:0] lat_word;
    logic        bd_we = 1'b0;
    logic [31:0] bd_addr = 32'd0, bd_data = 32'd0;

    always @(posedge clk) begin
        if (bd_we)
            mem_arr[bd_addr[11:2]] <= bd_data;
        else if (mem_ce && mem_we)
            mem_arr[mem_addr[11:2]] <= mem_wdata;
        else if (mem_ce && mem_rr)
            mem_rdata <= lat_word;
        else if (mem_ce)
            lat_word <= mem_arr[mem_addr[11:2]];
    end

    logic [7:0] ref_mem [4096];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
        int b;
        b = int'(a & 32'hFFC);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8];
        ref_mem[b+2] = d[23:16]; ref_mem[b+3] = d[31:24];
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
        int b;
        logic [31:0] v;
        b = int'(a & 32'hFFF);
        if (sz == 2'd0) begin
            v = {24'd0, ref_mem[b]};
            if (!un && v[7]) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            b = b - (b % 2);
            v = {16'd0, ref_mem[b+1], ref_mem[b]};
            if (!un && v[15]) v = v + 32'hFFFF0000;
        end else begin
            b = b - (b % 4);
            v = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int b;
        b = int'(a & 32'hFFF);
        if (sz == 2'd0) begin
            ref_mem[b] = d[7:0];
        end else if (sz == 2'd1) begin
            b = b - (b % 2);
            ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8];
        end else begin
            b = b - (b % 4);
            ref_mem[b] = d[7:0]; ref_mem[b+1] = d[15:8];
            ref_mem[b+2] = d[23:16]; ref_mem[b+3] = d[31:24];
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
`else
        return (a[0] && sz == 2'd3 && 1'b0);
`endif
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output logic [31:0] wword, output logic [31:0] waddr,
                          output logic ce_seen);
        int  n;
        logic got;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; got = 1'b0; rd = '0; er = 1'b0; wword = '0; waddr = '0; ce_seen = 1'b0;
        while (!got && lat < 12) begin
            @(negedge clk);
            lat++;
            if (mem_ce) ce_seen = 1'b1;
            if (mem_we) begin
                wword = mem_wdata;
                waddr = mem_addr;
            end
            if (resp_valid) begin
                got = 1'b1;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
        if (!got) lat = -1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t        vecs [8];
    int          lat;
    logic [31:0] rd, wword, waddr, last_rd, exp, w10, w20;
    logic        er, ce_seen, we, un, e;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    int          n;

    initial begin
        vecs[0] = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1, 32'h0, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 2'd0, 1'b0, 32'h22, 32'h000000AA, 3, 32'h0, 32'h11AA3344};
        vecs[3] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 3, 32'h11AA3344, 32'h0};
        vecs[4] = '{1'b0, 2'd0, 1'b0, 32'h32, 32'h0, 3, 32'hFFFFFFFF, 32'h0};
        vecs[5] = '{1'b0, 2'd0, 1'b1, 32'h32, 32'h0, 3, 32'h000000FF, 32'h0};
        vecs[6] = '{1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 3, 32'hFFFF80FF, 32'h0};
        vecs[7] = '{1'b0, 2'd1, 1'b1, 32'h30, 32'h0, 3, 32'h00007F01, 32'h0};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_mem_ctl", {29'd0, mem_ce, mem_we, mem_rr}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", {31'd0, resp_err}, 32'd0);
        chk("masks", {24'd0, mem_w_mask, mem_r_mask}, 32'h000000FF);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 1024; i++)
            bd_write(32'(i * 4), $urandom);
        bd_write(32'h20, 32'h11223344);
        bd_write(32'h30, 32'h80FF7F01);

        for (int i = 0; i < 8; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   lat, rd, er, wword, waddr, ce_seen);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_err", i), {31'd0, er}, 32'd0);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_wdata", i), wword, vecs[i].exp_wd);
                chk($sformatf("vec%0d_waddr", i), waddr, vecs[i].addr & 32'hFFFFFFFC);
                ref_store(vecs[i].addr, vecs[i].size, vecs[i].wdata);
            end else begin
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            end
        end
        last_rd = 32'h00007F01;

        // Two back-to-back loads with req_valid held high throughout
        w10 = ref_load(32'h10, 2'd2, 1'b0);
        w20 = ref_load(32'h20, 2'd2, 1'b0);
        @(negedge clk);
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_addr = 32'h20;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("hs1_ready_c%0d", k), {31'd0, req_ready}, 32'd0);
            chk($sformatf("hs1_valid_c%0d", k), {31'd0, resp_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
        chk("hs1_rdata", resp_rdata, w10);
        @(negedge clk);
        chk("hs_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("hs_idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("hs_rdata_hold", resp_rdata, w10);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("hs2_valid_c%0d", k), {31'd0, resp_valid}, (k == 3) ? 32'd1 : 32'd0);
        end
        chk("hs2_rdata", resp_rdata, w20);

        // Reset during the WRITE cycle of a byte store
        bd_write(32'h40, 32'h01020304);
        @(negedge clk);
        req_we = 1'b1; req_size = 2'd0; req_addr = 32'h41; req_wdata = 32'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_reached_write", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rstw_no_resp", {31'd0, resp_valid}, 32'd0);
        @(posedge clk); #1;
        chk("rstw_no_resp_edge", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstw_ready", {31'd0, req_ready}, 32'd1);
        chk("rstw_rdata_zero", resp_rdata, 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, lat, rd, er, wword, waddr, ce_seen);
        chk("rstw_mem_unchanged", rd, 32'h01020304);
        last_rd = rd;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, lat, rd, er, wword, waddr, ce_seen);
        chk("feat_mis_lat", 32'(lat), 32'd1);
        chk("feat_mis_err", {31'd0, er}, 32'd1);
        chk("feat_mis_noce", {31'd0, ce_seen}, 32'd0);
        chk("feat_mis_rdata", rd, last_rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'd0, lat, rd, er, wword, waddr, ce_seen);
        chk("feat_range_err", {31'd0, er}, 32'd1);
        chk("feat_range_noce", {31'd0, ce_seen}, 32'd0);
`endif

        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 8191));
            wd = $urandom;
            e  = ref_err(a, sz);
            do_req(we, sz, un, a, wd, lat, rd, er, wword, waddr, ce_seen);
            chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, e});
            if (e) begin
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd1);
                chk($sformatf("rnd%0d_hold", i), rd, last_rd);
                chk($sformatf("rnd%0d_noce", i), {31'd0, ce_seen}, 32'd0);
            end else if (!we) begin
                exp = ref_load(a, sz, un);
                chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd3);
                chk($sformatf("rnd%0d_rdata", i), rd, exp);
                last_rd = exp;
            end else begin
                ref_store(a, sz, wd);
                chk($sformatf("rnd%0d_lat", i), 32'(lat), sz[1] ? 32'd1 : 32'd3);
                chk($sformatf("rnd%0d_wdata", i), wword, ref_load(a, 2'd2, 1'b0));
                chk($sformatf("rnd%0d_waddr", i), waddr, a & 32'h00000FFC);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
